// File: rtl/vga_port_arbiter_if.sv
// Bundle between the drawing engines and the VGA port arbiter.
// master: engine side (requests and pixels); slave: arbiter side (grant and adapter stream).
interface vga_port_arbiter_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned CW = 3
);
  logic [2:0]      req;
  logic [2:0]      done;
  logic [3*XW-1:0] x_in;
  logic [3*YW-1:0] y_in;
  logic [3*CW-1:0] c_in;
  logic [2:0]      p_in;
  logic [2:0]      gnt;
  logic            busy;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot;

  modport master (
    output req, done, x_in, y_in, c_in, p_in,
    input  gnt, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, done, x_in, y_in, c_in, p_in,
    output gnt, busy, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/vga_port_arbiter.sv
// Shares the single VGA adapter write port between three drawing engines with registered outputs.
// Define VGA_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module vga_port_arbiter #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned CW = 3
) (
  input logic               clock,
  input logic               resetn,
  vga_port_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e        r_state, w_state_d;
  logic [1:0]    r_owner, w_owner_d;
  logic [1:0]    r_last_owner, w_last_owner_d;
  logic [2:0]    r_gnt, w_gnt_d;
  logic [XW-1:0] r_vga_x, w_vga_x_d;
  logic [YW-1:0] r_vga_y, w_vga_y_d;
  logic [CW-1:0] r_vga_colour, w_vga_colour_d;
  logic          r_vga_plot, w_vga_plot_d;

  logic [1:0]    w_winner;
  logic [XW-1:0] w_own_x;
  logic [YW-1:0] w_own_y;
  logic [CW-1:0] w_own_c;
  logic          w_own_plot, w_own_req, w_own_done;

  // Only the current owner's lanes are ever looked at.
  always_comb begin
    w_own_x    = io_bus.x_in[0 +: XW];
    w_own_y    = io_bus.y_in[0 +: YW];
    w_own_c    = io_bus.c_in[0 +: CW];
    w_own_plot = io_bus.p_in[0];
    w_own_req  = io_bus.req[0];
    w_own_done = io_bus.done[0];
    case (r_owner)
      2'd1: begin
        w_own_x    = io_bus.x_in[XW +: XW];
        w_own_y    = io_bus.y_in[YW +: YW];
        w_own_c    = io_bus.c_in[CW +: CW];
        w_own_plot = io_bus.p_in[1];
        w_own_req  = io_bus.req[1];
        w_own_done = io_bus.done[1];
      end
      2'd2: begin
        w_own_x    = io_bus.x_in[2*XW +: XW];
        w_own_y    = io_bus.y_in[2*YW +: YW];
        w_own_c    = io_bus.c_in[2*CW +: CW];
        w_own_plot = io_bus.p_in[2];
        w_own_req  = io_bus.req[2];
        w_own_done = io_bus.done[2];
      end
      default: ;
    endcase
  end

`ifdef VGA_ARB_RR_EN
  logic [1:0] w_s0, w_s1, w_s2;

  // Search order starts just after the previous owner and wraps 2 -> 0.
  always_comb begin
    w_s0 = 2'd0;
    w_s1 = 2'd1;
    w_s2 = 2'd2;
    case (r_last_owner)
      2'd0: begin w_s0 = 2'd1; w_s1 = 2'd2; w_s2 = 2'd0; end
      2'd1: begin w_s0 = 2'd2; w_s1 = 2'd0; w_s2 = 2'd1; end
      default: ;
    endcase
    w_winner = w_s2;
    if (io_bus.req[w_s0])      w_winner = w_s0;
    else if (io_bus.req[w_s1]) w_winner = w_s1;
  end
`else
  logic w_unused_last_owner;
  assign w_unused_last_owner = ^r_last_owner;

  always_comb begin
    w_winner = 2'd2;
    if (io_bus.req[0])      w_winner = 2'd0;
    else if (io_bus.req[1]) w_winner = 2'd1;
  end
`endif

  always_comb begin
    w_state_d      = r_state;
    w_owner_d      = r_owner;
    w_last_owner_d = r_last_owner;
    w_gnt_d        = r_gnt;
    w_vga_x_d      = r_vga_x;
    w_vga_y_d      = r_vga_y;
    w_vga_colour_d = r_vga_colour;
    w_vga_plot_d   = 1'b0;
    case (r_state)
      StIdle: begin
        if (|io_bus.req) begin
          w_owner_d = w_winner;
          w_gnt_d   = 3'b001 << w_winner;
          w_state_d = StOwn;
        end
      end
      StOwn: begin
        w_vga_x_d      = w_own_x;
        w_vga_y_d      = w_own_y;
        w_vga_colour_d = w_own_c;
        w_vga_plot_d   = w_own_plot;
        if (w_own_done || !w_own_req) begin
          w_gnt_d   = 3'b000;
          w_state_d = StGap;
        end
      end
      StGap: begin
        w_last_owner_d = r_owner;
        w_state_d      = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd2;
      r_gnt        <= 3'b000;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_last_owner <= w_last_owner_d;
      r_gnt        <= w_gnt_d;
      r_vga_x      <= w_vga_x_d;
      r_vga_y      <= w_vga_y_d;
      r_vga_colour <= w_vga_colour_d;
      r_vga_plot   <= w_vga_plot_d;
    end
  end

  assign io_bus.gnt        = r_gnt;
  assign io_bus.busy       = (r_state == StOwn);
  assign io_bus.vga_x      = r_vga_x;
  assign io_bus.vga_y      = r_vga_y;
  assign io_bus.vga_colour = r_vga_colour;
  assign io_bus.vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Directed bench for vga_port_arbiter; expected grant order follows VGA_ARB_RR_EN when defined.
module tb_vga_port_arbiter;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  vga_port_arbiter_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_port_arbiter #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .io_bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef VGA_ARB_RR_EN
  localparam int FirstCont = 2;
  int order [6] = '{0, 1, 2, 0, 1, 2};
`else
  localparam int FirstCont = 1;
  int order [6] = '{0, 0, 0, 0, 0, 0};
`endif

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.req  = 3'b111;
    bus.done = 3'b000;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.c_in = '0;
    bus.p_in = 3'b000;

    // Reset held two cycles with all requests high
    step();
    step();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_plot", 32'(bus.vga_plot), 32'h0);
    chk("rst_x", 32'(bus.vga_x), 32'h0);
    chk("rst_y", 32'(bus.vga_y), 32'h0);
    chk("rst_c", 32'(bus.vga_colour), 32'h0);

    resetn  = 1'b1;
    bus.req = 3'b000;
    step();

    // Single engine 1 burst of four pixels
    bus.req = 3'b010;
    step();
    chk("single_gnt", 32'(bus.gnt), 32'h2);
    chk("single_busy", 32'(bus.busy), 32'h1);
    for (int k = 0; k < 4; k++) begin
      bus.x_in[XW +: XW] = 8'(40 + k);
      bus.y_in[YW +: YW] = 7'd60;
      bus.c_in[CW +: CW] = 3'b011;
      bus.p_in           = 3'b010;
      step();
      chk("single_plot", 32'(bus.vga_plot), 32'h1);
      chk("single_x", 32'(bus.vga_x), 32'(40 + k));
      chk("single_y", 32'(bus.vga_y), 32'd60);
      chk("single_c", 32'(bus.vga_colour), 32'h3);
    end
    bus.done = 3'b010;
    bus.p_in = 3'b000;
    step();
    chk("gap_gnt", 32'(bus.gnt), 32'h0);
    chk("gap_busy", 32'(bus.busy), 32'h0);
    chk("gap_plot", 32'(bus.vga_plot), 32'h0);
    chk("gap_x_hold", 32'(bus.vga_x), 32'd43);

    // Engine 2 plots with no grant, during GAP and then IDLE
    bus.done             = 3'b000;
    bus.req              = 3'b000;
    bus.p_in             = 3'b100;
    bus.x_in[2*XW +: XW] = 8'd99;
    step();
    chk("mask_gap_plot", 32'(bus.vga_plot), 32'h0);
    chk("mask_gap_x", 32'(bus.vga_x), 32'd43);
    step();
    chk("mask_idle_plot", 32'(bus.vga_plot), 32'h0);
    chk("mask_idle_x", 32'(bus.vga_x), 32'd43);
    chk("mask_idle_gnt", 32'(bus.gnt), 32'h0);
    bus.p_in = 3'b000;

    // Contention: 110 then 111 while owned; non-owner done ignored
    bus.req = 3'b110;
    step();
    chk("cont_first", 32'(bus.gnt), 32'(1 << FirstCont));
    bus.req  = 3'b111;
    bus.done = 3'b001;
    step();
    chk("cont_hold", 32'(bus.gnt), 32'(1 << FirstCont));
    bus.done = 3'(1 << FirstCont);
    step();
    chk("cont_gap", 32'(bus.gnt), 32'h0);
    bus.done = 3'b000;
    bus.req  = 3'b111 & ~3'(1 << FirstCont);
    step();
    chk("cont_idle", 32'(bus.gnt), 32'h0);
    step();
    chk("cont_second", 32'(bus.gnt), 32'h1);
    step();
    bus.done = 3'b001;
    step();
    chk("cont_gap2", 32'(bus.gnt), 32'h0);
    bus.done = 3'b000;
    bus.req  = 3'b100;
    step();
    step();
    chk("cont_third", 32'(bus.gnt), 32'h4);
    bus.done = 3'b100;
    step();
    bus.done = 3'b000;
    bus.req  = 3'b000;
    step();
    step();
    chk("cont_end_idle", 32'(bus.gnt), 32'h0);

    // Reset during engine 0's third OWN cycle
    bus.req = 3'b001;
    step();
    chk("mid_gnt", 32'(bus.gnt), 32'h1);
    bus.x_in[0 +: XW] = 8'd5;
    bus.y_in[0 +: YW] = 7'd6;
    bus.c_in[0 +: CW] = 3'd7;
    bus.p_in          = 3'b001;
    step();
    chk("mid_plot", 32'(bus.vga_plot), 32'h1);
    chk("mid_x", 32'(bus.vga_x), 32'd5);
    step();
    resetn = 1'b0;
    step();
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_plot", 32'(bus.vga_plot), 32'h0);
    chk("mid_rst_x", 32'(bus.vga_x), 32'h0);
    chk("mid_rst_c", 32'(bus.vga_colour), 32'h0);
    resetn   = 1'b1;
    bus.p_in = 3'b000;
    bus.req  = 3'b111;
    step();

    // All three request continuously, two-cycle bursts
    for (int i = 0; i < 6; i++) begin
      chk("loop_gnt", 32'(bus.gnt), 32'(1 << order[i]));
      step();
      chk("loop_own2", 32'(bus.gnt), 32'(1 << order[i]));
      bus.done = 3'(1 << order[i]);
      step();
      chk("loop_gap", 32'(bus.gnt), 32'h0);
      chk("loop_gap_busy", 32'(bus.busy), 32'h0);
      bus.done = 3'b000;
      step();
      chk("loop_idle", 32'(bus.gnt), 32'h0);
      if (i == 5) bus.req = 3'b000;
      step();
    end
    chk("final_gnt", 32'(bus.gnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_port_arbiter.md
# vga_port_arbiter

Shares the single VGA adapter write port (x, y, colour, plot) between three drawing engines: background/road, sprites and end-game screen. Each engine requests the port, owns it exclusively until it signals done, and then releases it. Pixel outputs are registered, so the adapter sees one clean, glitch-free pixel stream. The block sits between the game top-level drawing FSMs and the VGA adapter.

## Interface
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- req  in  3  per-engine port request; bit i belongs to engine i
- done  in  3  per-engine end of burst; sampled only from the current owner
- x_in  in  3*XW  packed x coordinates; engine i uses bits [i*XW +: XW]
- y_in  in  3*YW  packed y coordinates
- c_in  in  3*CW  packed colours
- p_in  in  3  per-engine plot strobes
- gnt  out  3  one-hot grant, registered
- busy  out  1  port currently owned
- vga_x  out  XW  registered x to the adapter
- vga_y  out  YW  registered y to the adapter
- vga_colour  out  CW  registered colour to the adapter
- vga_plot  out  1  registered plot to the adapter

## Operation
- FSM states: IDLE, OWN, GAP.
- **IDLE**
  - If req is nonzero, select a winner, load owner, set gnt to one-hot(owner), then go to OWN.
  - Otherwise stay in IDLE.
- **OWN**
  - Forward the owner's x, y, colour and plot to the vga_* registers.
  - If done[owner]=1, or req[owner]=0, clear gnt and go to GAP.
  - The pixel presented in the same cycle as done is still forwarded.
- **GAP**
  - One dead cycle: vga_plot=0 and gnt=0.
  - Update last_owner to owner, then go to IDLE.
  - This guarantees one idle cycle between owners.
- **Output gating**
  - vga_plot is 0 outside OWN, regardless of p_in.
  - Outside OWN, vga_x, vga_y and vga_colour hold their last values.
- **Non-owner inputs**: req, done and p_in of non-owners are ignored while the port is owned. A pending req waits; it is never dropped.
- **Arbitration (default)**: fixed priority, engine 0 > engine 1 > engine 2.
- **busy** = (state == OWN).
- **Reset** (any cycle, including mid-burst). At the next edge:
  - state=IDLE
  - gnt=0, busy=0
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0
  - owner=0, last_owner=2

## Timing
- **Grant latency**: req rising with the FSM in IDLE at edge N gives gnt high after edge N+1.
- **Pixel latency**: an engine pixel (x_in/y_in/c_in/p_in) valid in cycle M appears on vga_* after edge M+1.
  - Engines may drive p_in only while their gnt is high.
  - Plots presented in the same cycle gnt rises are forwarded.
- **Release**: done[owner] high in cycle K gives gnt=0 after edge K+1. The earliest next grant is after edge K+3 (GAP, then IDLE, then grant).
- **Back-to-back bursts**: a single engine re-requesting is granted again through the same IDLE selection. Under round-robin it loses to other pending engines.
- **Simultaneous requests**: resolved in the one IDLE cycle; exactly one gnt bit is ever set.
- **Degenerate burst**: done and gnt in the same first OWN cycle gives a one-cycle ownership with at most one pixel.

## Configuration
- VGA_ARB_RR_EN defined: round-robin arbitration.
  - The search starts at (last_owner+1) mod 3 and wraps 2 to 0.
  - After reset the order is 0, 1, 2.
- VGA_ARB_RR_EN undefined: fixed priority (0 > 1 > 2).
  - last_owner is still tracked but unused.
  - Starvation of lower engines is permitted.

## Test plan
- **Reset**: hold resetn=0 for 2 cycles with req=3'b111 -> gnt=0, busy=0, vga_plot=0, all vga_* = 0.
- **Single engine**: engine 1 requests, then drives x=40, y=60, c=3'b011, p=1 for 4 cycles, then done -> gnt=3'b010 one edge after req; 4 plots appear on vga_* each one cycle late; GAP shows vga_plot=0.
- **Contention, fixed priority**: req=3'b110, then later 3'b111 while engine 1 owns -> engine 1 finishes its burst; next grant goes to engine 0; engine 2 is granted only after engine 0 releases.
- **Contention, RR (VGA_ARB_RR_EN)**: all three hold req and each burst is 2 cycles -> grant order 0, 1, 2, 0, 1, 2; exactly one GAP cycle between grants.
- **Plot masking**: engine 2 drives p_in=1 without a grant, and again during a GAP -> vga_plot stays 0.
- **Reset mid-burst**: resetn=0 during engine 0's OWN cycle 3 -> gnt=0 and vga_plot=0 at the next edge. After release, req=3'b111 grants engine 0.
